// File: rtl/bconv_pkg.sv
// bconv_pkg: shared sizes and FSM encoding for the binary conv + pool stage
package bconv_pkg;
    localparam int KW    = 7;
    localparam int CH    = 8;
    localparam int POOL  = 2;
    localparam int N_WIN = 464;
    localparam int THR_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bconv_xnor_pop.sv
// bconv_xnor_pop: XNOR-popcount of one window against one kernel, thresholded to a bit
module bconv_xnor_pop
    import bconv_pkg::*;
#(
    parameter int W = KW
) (
    input  logic [W-1:0]     win,
    input  logic [W-1:0]     kern,
    input  logic [THR_W-1:0] thr,
    output logic             act
);
    localparam int PW = $clog2(W + 1);
    logic [PW-1:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) pop = pop + {{(PW-1){1'b0}}, ~(win[i] ^ kern[i])};
    end
    assign act = THR_W'(pop) >= thr;
endmodule

// File: rtl/bconv1_pool.sv
// bconv1_pool: per-channel binary conv on each window, then OR-pools POOL windows per output word
module bconv1_pool #(
    parameter int CH    = bconv_pkg::CH,
    parameter int KW    = bconv_pkg::KW,
    parameter int POOL  = bconv_pkg::POOL,
    parameter int N_WIN = bconv_pkg::N_WIN
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KW-1:0]               slide_data,
    input  logic                        ecg_data_val,
    input  logic                        trans_done,
    input  logic                        cfg_we,
    input  logic [$clog2(CH)-1:0]       cfg_addr,
    input  logic [KW-1:0]               cfg_w,
    input  logic [bconv_pkg::THR_W-1:0] cfg_thr,
    input  logic                        frame_clr,
    output logic [CH-1:0]               act_data,
    output logic                        act_val,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        src_done_seen
);
    import bconv_pkg::*;
    localparam int WC_W = $clog2(N_WIN + 1);
    localparam int PC_W = POOL > 1 ? $clog2(POOL) : 1;
    state_t state, state_nx;
    logic [WC_W-1:0]  win_cnt;
    logic [PC_W-1:0]  pool_cnt;
    logic [KW-1:0]    kern [CH];
    logic [THR_W-1:0] thr  [CH];
    logic [CH-1:0]    act, bits_q, pool_acc;
    logic             s1_val, s1_last, s2_last;
    logic             accept, last_win, cfg_ok, pool_full;

    assign accept    = ecg_data_val && state != DONE;
    assign last_win  = accept && win_cnt == WC_W'(N_WIN - 1);
    assign cfg_ok    = cfg_we && state != RUN && int'(cfg_addr) < CH;
    assign pool_full = s1_last || pool_cnt == PC_W'(POOL - 1);
    assign busy      = state == RUN;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        bconv_xnor_pop #(.W(KW)) u_pop (
            .win (slide_data),
            .kern(kern[c]),
            .thr (thr[c]),
            .act (act[c])
        );
    end

    always_comb begin
        state_nx = state;
        if (last_win) state_nx = DONE;
        else if (state == IDLE && ecg_data_val) state_nx = RUN;
        else if (state == DONE && frame_clr) state_nx = IDLE;
    end

    // Threshold 8 exceeds any popcount, so the reset config yields all-zero activations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                kern[i] <= '0;
                thr[i]  <= THR_W'(8);
            end
        end else if (cfg_ok) begin
            kern[cfg_addr] <= cfg_w;
            thr[cfg_addr]  <= cfg_thr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            win_cnt       <= '0;
            pool_cnt      <= '0;
            pool_acc      <= '0;
            bits_q        <= '0;
            s1_val        <= 1'b0;
            s1_last       <= 1'b0;
            s2_last       <= 1'b0;
            act_data      <= '0;
            act_val       <= 1'b0;
            frame_done    <= 1'b0;
            src_done_seen <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) win_cnt <= win_cnt + WC_W'(1);
            else if (state == DONE && frame_clr) win_cnt <= '0;
            s1_val  <= accept;
            s1_last <= last_win;
            if (accept) bits_q <= act;
            act_val    <= s1_val && pool_full;
            s2_last    <= s1_val && s1_last;
            frame_done <= s2_last;
            // Last window of the frame closes a partial group as its own word
            if (s1_val && pool_full) begin
                act_data <= pool_acc | bits_q;
                pool_acc <= '0;
                pool_cnt <= '0;
            end else if (s1_val) begin
                pool_acc <= pool_acc | bits_q;
                pool_cnt <= pool_cnt + PC_W'(1);
            end
            src_done_seen <= trans_done | (src_done_seen & ~frame_clr);
        end
    end
endmodule

// File: tb/tb_bconv1_pool.sv
// tb_bconv1_pool: randomized frames checked against a window-list reference model
module tb_bconv1_pool;
    localparam int NW  = 464;
    localparam int NW5 = 5;

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] slide_data = '0, cfg_w = '0;
    logic       ecg_data_val = 1'b0, val5 = 1'b0, trans_done = 1'b0, cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [3:0] cfg_thr = '0;
    logic       frame_clr = 1'b0, clr5 = 1'b0;
    logic [7:0] act_data, act_data5;
    logic       act_val, busy, frame_done, src_done_seen;
    logic       act_val5, busy5, frame_done5, src_done_seen5;

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [7:0] gw0[$], gw5[$];
    int         gc0[$], gc5[$], gd0[$], gd5[$];
    logic [6:0] mw[8];
    logic [3:0] mt[8];
    logic [6:0] wq[$];
    int         aq[$];

    bconv1_pool u_dut (
        .clk(clk), .rst(rst), .slide_data(slide_data), .ecg_data_val(ecg_data_val),
        .trans_done(trans_done), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w(cfg_w),
        .cfg_thr(cfg_thr), .frame_clr(frame_clr), .act_data(act_data), .act_val(act_val),
        .busy(busy), .frame_done(frame_done), .src_done_seen(src_done_seen)
    );

    bconv1_pool #(.N_WIN(NW5)) u_dut5 (
        .clk(clk), .rst(rst), .slide_data(slide_data), .ecg_data_val(val5),
        .trans_done(trans_done), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w(cfg_w),
        .cfg_thr(cfg_thr), .frame_clr(clr5), .act_data(act_data5), .act_val(act_val5),
        .busy(busy5), .frame_done(frame_done5), .src_done_seen(src_done_seen5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (act_val) begin gw0.push_back(act_data); gc0.push_back(cyc); end
        if (frame_done) gd0.push_back(cyc);
        if (act_val5) begin gw5.push_back(act_data5); gc5.push_back(cyc); end
        if (frame_done5) gd5.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] act_of(input logic [6:0] x);
        logic [7:0] a;
        for (int c = 0; c < 8; c++) a[c] = $countones(~(x ^ mw[c])) >= int'(mt[c]);
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input logic [6:0] w, input logic [3:0] t);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_w = w; cfg_thr = t;
        step();
        cfg_we = 1'b0;
        mw[a] = w;
        mt[a] = t;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin mw[c] = '0; mt[c] = 4'd8; end
    endtask

    task automatic pulse_clr();
        frame_clr = 1'b1; clr5 = 1'b1;
        step();
        frame_clr = 1'b0; clr5 = 1'b0;
    endtask

    // Window 1 always follows two idle cycles, giving a 1,0,0,1 valid pattern inside group 0
    task automatic send(input int n, input int gap_pct, input bit to5, input bit mid_cfg, input bit fixed2);
        logic [6:0] x;
        int k;
        wq.delete(); aq.delete();
        for (int i = 0; i < n; i++) begin
            k = (i == 1) ? 2 : (int'($urandom_range(99)) < gap_pct ? int'($urandom_range(3, 1)) : 0);
            repeat (k) begin ecg_data_val = 1'b0; val5 = 1'b0; step(); end
            x = fixed2 && i < 2 ? (i == 0 ? 7'b1010101 : 7'b0101010) : 7'($urandom);
            slide_data = x;
            ecg_data_val = !to5;
            val5 = to5;
            trans_done = (i == n / 2);
            if (mid_cfg && i == 50) begin cfg_we = 1'b1; cfg_addr = 3'd3; cfg_w = 7'h7f; cfg_thr = 4'd0; end
            if (!to5 && i == 10) check("busy_run", busy, 1);
            wq.push_back(x);
            aq.push_back(cyc);
            step();
            cfg_we = 1'b0;
            trans_done = 1'b0;
        end
        ecg_data_val = 1'b0;
        val5 = 1'b0;
    endtask

    task automatic check_frame(input bit d, input int n);
        logic [7:0] w[$];
        logic [7:0] acc;
        int c[$], dn[$];
        int k, last;
        repeat (6) step();
        if (d) begin w = gw5; c = gc5; dn = gd5; end
        else begin w = gw0; c = gc0; dn = gd0; end
        gw0.delete(); gc0.delete(); gd0.delete(); gw5.delete(); gc5.delete(); gd5.delete();
        check("n_words", w.size(), (n + 1) / 2);
        acc = '0; k = 0; last = 0;
        for (int i = 0; i < n; i++) begin
            acc |= act_of(wq[i]);
            if (i % 2 == 1 || i == n - 1) begin
                if (k < w.size()) begin
                    check("word", w[k], acc);
                    check("latency", c[k], aq[i] + 2);
                end
                k++;
                acc = '0;
                last = aq[i] + 3;
            end
        end
        check("n_done", dn.size(), 1);
        if (dn.size() > 0) check("done_cyc", dn[0], last);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_act_val", act_val, 0);
        check("rst_act_data", act_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_src_done", src_done_seen, 0);
        rst = 1'b0;
        step();

        // Single-kernel match: first word must be 8'h01
        cfg(0, 7'b1010101, 4'd7);
        send(NW, 30, 1'b0, 1'b0, 1'b1);
        check("first_word_const", gw0.size() > 0 ? gw0[0] : 8'hxx, 8'h01);
        check_frame(1'b0, NW);
        check("busy_done", busy, 0);
        check("src_done_set", src_done_seen, 1);
        ecg_data_val = 1'b1;
        repeat (4) step();
        ecg_data_val = 1'b0;
        repeat (4) step();
        check("ignored_in_done", gw0.size(), 0);
        pulse_clr();
        check("src_done_clr", src_done_seen, 0);

        // All thresholds 0, continuous stream
        for (int c = 0; c < 8; c++) cfg(c, 7'($urandom), 4'd0);
        send(NW, 0, 1'b0, 1'b0, 1'b0);
        check("thr0_word", gw0.size() > 0 ? gw0[0] : 8'h00, 8'hFF);
        check_frame(1'b0, NW);
        ecg_data_val = 1'b1;
        step();
        ecg_data_val = 1'b0;
        repeat (4) step();
        check("win465_ignored", gw0.size(), 0);
        check("win465_busy", busy, 0);
        pulse_clr();

        // Config write during RUN must be ignored
        for (int c = 0; c < 8; c++) cfg(c, 7'($urandom), 4'($urandom_range(8)));
        cfg(3, 7'h7f, 4'd8);
        send(NW, 20, 1'b0, 1'b1, 1'b0);
        check_frame(1'b0, NW);
        pulse_clr();
        cfg(3, 7'h7f, 4'd0);
        send(NW, 10, 1'b0, 1'b0, 1'b0);
        check_frame(1'b0, NW);
        pulse_clr();

        // Reset mid-frame
        send(100, 10, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_act_val", act_val, 0);
        check("mid_rst_act_data", act_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_src_done", src_done_seen, 0);
        step();
        rst = 1'b0;
        model_reset();
        step();
        gw0.delete(); gc0.delete(); gd0.delete(); gw5.delete(); gc5.delete(); gd5.delete();
        send(NW, 10, 1'b0, 1'b0, 1'b0);
        check("post_rst_word", gw0.size() > 0 ? gw0[0] : 8'hxx, 8'h00);
        check_frame(1'b0, NW);

        // Short frame with a trailing partial group
        for (int c = 0; c < 8; c++) cfg(c, 7'($urandom), 4'($urandom_range(8)));
        send(NW5, 30, 1'b1, 1'b0, 1'b0);
        check_frame(1'b1, NW5);
        check("busy5_done", busy5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
